tx_piso_serializer: RTL and testbench
=====================================

Name: tx_piso_serializer

Overview:
Synthesizable parallel-in/serial-out stage for the channel model's TX path, running on the fast serial-rate clock.
- Accepts parallel words through a valid/ready handshake and shifts them out LSB-first, one bit per clock.
- Generates the matching divided word clock internally from its bit counter.
- Supports 16/20/32/40-bit word widths. Width changes take effect only at word boundaries.
- Signals underflow and inserts an idle word when the source is late.

Parameters:
- MAX_WIDTH, 40, width of in_data and of the internal shift register.
- IDLE_WORD, 40'h0, word shifted out when no data is accepted at a load point; LSBs used for narrower widths.

Ports:
- clk_in  input  1  serial-rate clock; every register is on its rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous; deassertion is sampled on clk_in.
- en  input  1  run enable; sampled at word boundaries only.
- width_sel  input  2  word width: 0=16, 1=20, 2=32, 3=40; sampled at load points only.
- in_data  input  MAX_WIDTH  parallel word; bit 0 is transmitted first.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  load point; the word is accepted when in_ready and in_valid are both high.
- ser_out  output  1  serial bit stream.
- word_clk  output  1  divided clock, period W cycles.
- underflow  output  1  one-cycle pulse after a load point with no valid data.
- busy  output  1  high while in state RUN.

Behaviour:
- Registered state:
  - state: IDLE or RUN.
  - bit_cnt: 6 bits.
  - w_cur: latched decoded width.
  - sr: MAX_WIDTH-bit shift register.
  - word_clk and underflow registers.
- Reset values: state=IDLE, bit_cnt=0, sr=0, w_cur=decode(0)=16. All outputs are 0 during reset and until the first RUN cycle.
- IDLE:
  - ser_out=0, word_clk=0, in_ready=0, busy=0.
  - If en=1: next state RUN, w_cur<=decode(width_sel), bit_cnt<=w_cur_new-1. The first RUN cycle is therefore a load point.
- RUN, definitions:
  - busy=1.
  - in_ready is combinational: (state==RUN) && (bit_cnt==w_cur-1).
  - ser_out=sr[0].
- RUN, non-load cycle: sr<=sr>>1 (zero fill), bit_cnt<=bit_cnt+1.
- RUN, load cycle (bit_cnt==w_cur-1):
  - If en=0: next state IDLE, sr<=0. A word accepted that same cycle is not allowed, so in_ready is forced low when en=0 at the load point.
  - Else if in_valid=1: sr<=in_data, bit_cnt<=0, w_cur<=decode(width_sel).
  - Else: sr<=IDLE_WORD, bit_cnt<=0, w_cur<=decode(width_sel), underflow<=1 for exactly one cycle.
- Latency: a word accepted in cycle t puts its bit k on ser_out in cycle t+1+k, for k=0..W-1. Back-to-back words are gapless.
- In-flight word is unaffected by:
  - width_sel changes mid-word; the new width applies starting with the word loaded at the next load point.
  - en deasserted mid-word; the current word completes before the block returns to IDLE.
- Bits above W-1 of in_data are ignored. Only bits 0..W-1 reach ser_out, because the reload happens at W-1.
- word_clk:
  - Registered; the next value is (bit_cnt_next < w_next/2) while in RUN, and 0 when going to IDLE.
  - High while bits 0..W/2-1 of a word are on ser_out, low for bits W/2..W-1; 50% duty for every width.
- Reset mid-word: output drops immediately. After release the block restarts from IDLE with no partial word.

Decomposition:
- Shared package tx_piso_pkg:
  - width_sel encoding constants WSEL_16/20/32/40.
  - decode function returning 6-bit width.
  - state enum IDLE/RUN.
- No sub-module is needed; a single module keeps the counter and shift register together.

Test Plan:
- Width 20, en=1, continuous valid words 0x5A3C1, 0xFFFFF -> ser_out carries 0x5A3C1 LSB first (1,0,0,0,0,0,1,1,...) starting 1 cycle after acceptance, then 0xFFFFF with no gap. in_ready pulses every 20 cycles.
- Width 16: word_clk is high 8 cycles and low 8 cycles, aligned so that the rising edge coincides with bit 0 on ser_out.
- in_valid low at one load point -> 20 bits of IDLE_WORD (0) on ser_out, underflow=1 for exactly 1 cycle, next valid word is gapless.
- Change width_sel 20->40 mid-word -> current word completes at 20 bits. The next in_ready comes 20 cycles later, the following in_ready 40 cycles after that, and word_clk period becomes 40.
- Deassert en at bit 5 of a 32-bit word -> remaining 26 bits are transmitted. in_ready stays low, then IDLE with ser_out=0 and busy=0.
- Assert rst_n=0 asynchronously at bit 10 -> ser_out, word_clk, busy and in_ready drop to 0 immediately without waiting for a clock. After release with en=1, the first in_ready appears 2 cycles after the first sampled edge.

Source files
------------

// File: rtl/tx_piso_pkg.sv
// Shared definitions for the TX parallel-in/serial-out stage: width select
// encoding, width decode and the FSM state type.
package tx_piso_pkg;

  localparam logic [1:0] WSEL_16 = 2'd0;
  localparam logic [1:0] WSEL_20 = 2'd1;
  localparam logic [1:0] WSEL_32 = 2'd2;
  localparam logic [1:0] WSEL_40 = 2'd3;

  localparam int BIT_CNT_W = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [BIT_CNT_W-1:0] decode_width(input logic [1:0] sel);
    logic [BIT_CNT_W-1:0] w;
    case (sel)
      WSEL_16: w = 6'd16;
      WSEL_20: w = 6'd20;
      WSEL_32: w = 6'd32;
      WSEL_40: w = 6'd40;
      default: w = 6'd16;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tx_piso_if.sv
// Parallel word handshake into the serializer.
interface tx_piso_if #(
  parameter int MAX_WIDTH = 40
) ();

  // A word transfers on a rising clk_in edge where in_valid and in_ready are
  // both high. in_ready is high only at a load point of a running serializer
  // with en set; the source may hold or change in_data freely otherwise.
  logic [MAX_WIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/tx_piso_serializer.sv
// Serial-rate PISO: loads a word at each load point, shifts it out LSB-first,
// and derives a 50% duty word clock from the bit counter.
module tx_piso_serializer
  import tx_piso_pkg::*;
#(
  parameter int                   MAX_WIDTH = 40,
  parameter logic [MAX_WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  width_sel,
  tx_piso_if.slave    in_if,
  output logic        ser_out,
  output logic        word_clk,
  output logic        underflow,
  output logic        busy,
  output state_t      dbg_state
);

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BIT_CNT_W-1:0] w_bit_cnt_nxt;
  logic [BIT_CNT_W-1:0] r_w_cur;
  logic [BIT_CNT_W-1:0] w_w_cur_nxt;
  logic [BIT_CNT_W-1:0] w_width_new;
  logic [MAX_WIDTH-1:0] r_sr;
  logic [MAX_WIDTH-1:0] w_sr_nxt;
  logic                 r_word_clk;
  logic                 w_word_clk_nxt;
  logic                 r_underflow;
  logic                 w_underflow_nxt;
  logic                 w_load_pt;

  // Reset asserts asynchronously; release passes through two flops so the
  // datapath leaves reset on a clean edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_width_new = decode_width(width_sel);
  assign w_load_pt   = (r_state == RUN) && (r_bit_cnt == (r_w_cur - 6'd1));

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_w_cur_nxt     = r_w_cur;
    w_sr_nxt        = r_sr;
    w_underflow_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          // Entering at W-1 makes the first RUN cycle a load point.
          w_state_nxt   = RUN;
          w_w_cur_nxt   = w_width_new;
          w_bit_cnt_nxt = w_width_new - 6'd1;
        end
      end
      RUN: begin
        if (w_load_pt) begin
          if (!en) begin
            w_state_nxt   = IDLE;
            w_sr_nxt      = '0;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = '0;
            w_w_cur_nxt   = w_width_new;
            if (in_if.in_valid) begin
              w_sr_nxt = in_if.in_data;
            end else begin
              w_sr_nxt        = IDLE_WORD;
              w_underflow_nxt = 1'b1;
            end
          end
        end else begin
          w_sr_nxt      = {1'b0, r_sr[MAX_WIDTH-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + 6'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // High for the first half of each word's bits, so it rises with bit 0.
  assign w_word_clk_nxt = (w_state_nxt == RUN) && (w_bit_cnt_nxt < (w_w_cur_nxt >> 1));

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_w_cur     <= decode_width(WSEL_16);
      r_sr        <= '0;
      r_word_clk  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_w_cur     <= w_w_cur_nxt;
      r_sr        <= w_sr_nxt;
      r_word_clk  <= w_word_clk_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  // A word may not be taken at the load point where the block stops.
  assign in_if.in_ready = w_load_pt && en;

  assign ser_out   = (r_state == RUN) && r_sr[0];
  assign word_clk  = r_word_clk;
  assign underflow = r_underflow;
  assign busy      = (r_state == RUN);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tx_piso_serializer.sv
// Bench for tx_piso_serializer: a bit-level scoreboard filled at each load
// point and drained one entry per cycle against ser_out/word_clk/underflow.
module tb_tx_piso_serializer;
  import tx_piso_pkg::*;

  localparam int              MAXW   = 40;
  localparam logic [MAXW-1:0] IDLE_W = 40'h0;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] width_sel;
  logic       ser_out;
  logic       word_clk;
  logic       underflow;
  logic       busy;
  state_t     dbg_state;

  tx_piso_if #(.MAX_WIDTH(MAXW)) bus ();

  tx_piso_serializer #(
    .MAX_WIDTH(MAXW),
    .IDLE_WORD(IDLE_W)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .width_sel(width_sel),
    .in_if    (bus),
    .ser_out  (ser_out),
    .word_clk (word_clk),
    .underflow(underflow),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // scoreboard: {ser_out, word_clk, underflow} per cycle
  logic [2:0]  exp_q[$];
  logic [40:0] src_q[$];
  int          rdy_hist[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          uf_seen = 0;
  int          m_rst_wait = 2;
  int          m_cur_w = 0;
  logic        m_run = 1'b0;
  int          rel1, rel2, wc_idx, idx2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int width_of(input logic [1:0] s);
    case (s)
      2'd0:    return 16;
      2'd1:    return 20;
      2'd2:    return 32;
      default: return 40;
    endcase
  endfunction

  task automatic push_word(input logic [MAXW-1:0] d, input int w, input logic uf);
    for (int k = 0; k < w; k++) begin
      exp_q.push_back({d[k], (k < w / 2), (uf && (k == 0))});
    end
    m_cur_w = w;
  endtask

  // driver
  task automatic drive_src();
    if (src_q.size() > 0) begin
      bus.in_valid = src_q[0][40];
      bus.in_data  = src_q[0][39:0];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
    end
  endtask

  // One cycle: called just after a falling edge with inputs settled.
  task automatic cycle();
    logic       exp_load;
    logic [2:0] exp_o;
    #1;
    exp_load = m_run && (exp_q.size() <= 1);
    chk("in_ready", bus.in_ready, exp_load && en);
    chk("busy", busy, m_run);
    chk("dbg_state", dbg_state, m_run);
    if (exp_q.size() > 0) exp_o = exp_q.pop_front();
    else                  exp_o = 3'b000;
    chk("ser_out", ser_out, exp_o[2]);
    chk("word_clk", word_clk, exp_o[1]);
    chk("underflow", underflow, exp_o[0]);
    if (bus.in_ready) rdy_hist.push_back(cyc);
    if (underflow) uf_seen++;
    if (!rst_n) begin
      m_run      = 1'b0;
      m_rst_wait = 2;
      exp_q.delete();
    end else if (!m_run) begin
      if (m_rst_wait > 0) m_rst_wait--;
      else if (en) m_run = 1'b1;
    end else if (exp_load) begin
      if (!en) begin
        m_run = 1'b0;
      end else begin
        if (bus.in_valid) push_word(bus.in_data, width_of(width_sel), 1'b0);
        else              push_word(IDLE_W, width_of(width_sel), 1'b1);
        if (src_q.size() > 0) src_q.delete(0);
      end
    end
    cyc++;
    @(negedge clk_in);
    drive_src();
  endtask

  initial begin
    logic [63:0] rnd;
    rst_n        = 1'b0;
    en           = 1'b0;
    width_sel    = 2'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk_in);
    repeat (3) cycle();

    // streaming: width 20, underflow gap, 16-bit words, 20->40 change, en drop
    width_sel = 2'd1;
    en        = 1'b1;
    src_q.push_back({1'b1, 40'hABCDE5A3C1});
    src_q.push_back({1'b1, 40'h12345FFFFF});
    src_q.push_back({1'b0, 40'hDEAD0BEEF0});
    src_q.push_back({1'b1, 40'h00000A5A5A});
    src_q.push_back({1'b1, 40'hFFFFFF1234});
    src_q.push_back({1'b1, 40'h000000BEEF});
    src_q.push_back({1'b1, 40'h55555C0FFE});
    src_q.push_back({1'b1, 40'h8000000001});
    src_q.push_back({1'b1, 40'h0123456789});
    src_q.push_back({1'b1, 40'hF0F0F0F0F0});
    src_q.push_back({1'b1, 40'hAA9ABCDEF0});
    drive_src();
    rst_n = 1'b1;
    rel1  = cyc;
    wc_idx = 0;
    for (int r = 0; r < 296; r++) begin
      case (r)
        70:  width_sel = 2'd0;
        105: width_sel = 2'd1;
        120: begin
          width_sel = 2'd3;
          wc_idx    = rdy_hist.size();
        end
        220: width_sel = 2'd2;
        261: en = 1'b0;
        default: ;
      endcase
      cycle();
    end
    chk("t1_rdy_count", rdy_hist.size(), 11);
    chk("t1_uf_pulses", uf_seen, 1);
    if (rdy_hist.size() >= 11) begin
      chk("t1_first_rdy", rdy_hist[0] - rel1, 3);
      chk("t1_rdy_gap", rdy_hist[1] - rdy_hist[0], 20);
      chk("wchg_gap20", rdy_hist[wc_idx] - rdy_hist[wc_idx - 1], 20);
      chk("wchg_gap40", rdy_hist[wc_idx + 1] - rdy_hist[wc_idx], 40);
    end

    // random widths and valid gaps
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rnd = {$urandom, $urandom};
      src_q.push_back({($urandom_range(0, 4) != 0), rnd[39:0]});
    end
    drive_src();
    for (int i = 0; i < 800; i++) begin
      if (src_q.size() == 0) break;
      if ($urandom_range(0, 15) == 0) width_sel = 2'($urandom_range(0, 3));
      cycle();
    end
    chk("rand_drain", src_q.size(), 0);

    // asynchronous reset at bit 10 of a 32-bit word
    width_sel = 2'd2;
    src_q.push_back({1'b1, 40'hFF00000401});
    drive_src();
    for (int i = 0; i < 200; i++) begin
      if (src_q.size() == 0 && m_cur_w == 32 && exp_q.size() == 22) break;
      cycle();
    end
    chk("rst_align", exp_q.size(), 22);
    #2;
    chk("pre_rst_ser", ser_out, 1'b1);
    chk("pre_rst_wclk", word_clk, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_word_clk", word_clk, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    exp_q.delete();
    src_q.delete();
    m_run      = 1'b0;
    m_rst_wait = 2;
    @(negedge clk_in);
    drive_src();
    repeat (2) cycle();
    rst_n = 1'b1;
    rel2  = cyc;
    idx2  = rdy_hist.size();
    repeat (8) cycle();
    chk("rst_rdy_seen", rdy_hist.size() > idx2, 1'b1);
    if (rdy_hist.size() > idx2) chk("rst_first_rdy", rdy_hist[idx2] - rel2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
